// File: rtl/arm_id_pkg.sv
// Shared ARM decode definitions: EXE_CMD codes, instruction field enums,
// scoreboard entry type and the condition-code evaluator.
package arm_id_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_TST = 4'b1000,
    OP_CMP = 4'b1010,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_MVN = 4'b1111
  } dp_op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
    CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
    CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
    CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       is_load;
  } sb_entry_t;

  // flags = {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cc)
      CC_EQ:   cond_pass = z;
      CC_NE:   cond_pass = !z;
      CC_CS:   cond_pass = c;
      CC_CC:   cond_pass = !c;
      CC_MI:   cond_pass = n;
      CC_PL:   cond_pass = !n;
      CC_VS:   cond_pass = v;
      CC_VC:   cond_pass = !v;
      CC_HI:   cond_pass = c && !z;
      CC_LS:   cond_pass = !c || z;
      CC_GE:   cond_pass = (n == v);
      CC_LT:   cond_pass = (n != v);
      CC_GT:   cond_pass = !z && (n == v);
      CC_LE:   cond_pass = z || (n != v);
      // AL and the unused NV slot both execute unconditionally
      default: cond_pass = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_sb_if.sv
// IF/ID, writeback and ID/EX signals of the decode stage bundled as one interface.
// master: the surrounding pipeline (drives instruction, flags, WB, stalls).
// slave:  the decode stage itself.
interface id_stage_sb_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            inst_valid;
  logic [31:0]     inst;
  logic [PC_W-1:0] pc;
  logic            inst_ready;
  logic            freeze;
  logic            flush;
  logic [3:0]      sr;
  logic            wb_en;
  logic [3:0]      wb_dest;
  logic [XLEN-1:0] wb_value;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [3:0]      ex_cmd;
  logic            ex_s;
  logic            ex_b;
  logic            ex_mem_r;
  logic            ex_mem_w;
  logic            ex_wb_en;
  logic            ex_imm;
  logic [11:0]     ex_shift_operand;
  logic [23:0]     ex_simm24;
  logic [XLEN-1:0] ex_val_rn;
  logic [XLEN-1:0] ex_val_rm;
  logic [3:0]      ex_dest;
  logic [3:0]      ex_src1;
  logic [3:0]      ex_src2;

  modport master (
    output inst_valid, inst, pc, freeze, flush, sr, wb_en, wb_dest, wb_value,
    input  inst_ready, ex_valid, ex_pc, ex_cmd, ex_s, ex_b, ex_mem_r, ex_mem_w,
           ex_wb_en, ex_imm, ex_shift_operand, ex_simm24, ex_val_rn, ex_val_rm,
           ex_dest, ex_src1, ex_src2
  );

  modport slave (
    input  inst_valid, inst, pc, freeze, flush, sr, wb_en, wb_dest, wb_value,
    output inst_ready, ex_valid, ex_pc, ex_cmd, ex_s, ex_b, ex_mem_r, ex_mem_w,
           ex_wb_en, ex_imm, ex_shift_operand, ex_simm24, ex_val_rn, ex_val_rm,
           ex_dest, ex_src1, ex_src2
  );
endinterface

// File: rtl/id_scoreboard.sv
// In-flight destination tracker for the decode stage.
// Entry 0 mirrors the instruction in ID/EX; older entries follow it down the pipe.
// Build option ID_FWD_EN: downstream forwarding exists, so only a load sitting
// in entry 0 can stall (load-use); otherwise any matching entry stalls.
module id_scoreboard
  import arm_id_pkg::*;
#(
  parameter int SB_DEPTH = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      freeze_i,
  input  logic      flush_i,
  input  sb_entry_t push_i,
  input  logic      use_src1_i,
  input  logic [3:0] src1_i,
  input  logic      use_src2_i,
  input  logic [3:0] src2_i,
  output logic      hazard_o
);

`ifdef ID_FWD_EN
  localparam bit                    LoadOnly  = 1'b1;
  localparam logic [SB_DEPTH-1:0] StallMask = SB_DEPTH'(1);
`else
  localparam bit                    LoadOnly  = 1'b0;
  localparam logic [SB_DEPTH-1:0] StallMask = {SB_DEPTH{1'b1}};
`endif

  sb_entry_t          sb_q [SB_DEPTH];
  sb_entry_t          sb_d [SB_DEPTH];
  logic [SB_DEPTH-1:0] hit;

  // shift while the pipe moves; a flush always clears the youngest slot
  always_comb begin
    sb_d = sb_q;
    if (!freeze_i) begin
      sb_d[0] = push_i;
      for (int i = 1; i < SB_DEPTH; i++) sb_d[i] = sb_q[i-1];
    end
    if (flush_i) sb_d[0].valid = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // per-entry source match; stall mask selects which entries may stall
  always_comb begin
    hit = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      hit[i] = sb_q[i].valid && (!LoadOnly || sb_q[i].is_load) &&
               ((use_src1_i && (sb_q[i].dest == src1_i)) ||
                (use_src2_i && (sb_q[i].dest == src2_i)));
    end
  end

  assign hazard_o = |(hit & StallMask);

endmodule

// File: rtl/id_stage_sb.sv
// ARM decode stage with local hazard scoreboard and registered ID/EX outputs.
// Decode, condition check and the 16-entry register file live here; the
// scoreboard is in id_scoreboard. Build option ID_FWD_EN (see id_scoreboard)
// relaxes stalls to load-use only.
module id_stage_sb
  import arm_id_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_W     = 32,
  parameter int SB_DEPTH = 3
) (
  input logic         clk,
  input logic         rst,
  id_stage_sb_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [3:0]      cmd;
    logic            s;
    logic            b;
    logic            mem_r;
    logic            mem_w;
    logic            wb_en;
    logic            imm;
    logic [11:0]     shift_operand;
    logic [23:0]     simm24;
    logic [XLEN-1:0] val_rn;
    logic [XLEN-1:0] val_rm;
    logic [3:0]      dest;
    logic [3:0]      src1;
    logic [3:0]      src2;
  } idex_t;

  logic [XLEN-1:0] rf_q [16];

  logic [1:0]      mode;
  logic [3:0]      op;
  logic            s_bit, imm_bit;
  logic [3:0]      rn, rd, rm, src2;
  logic [3:0]      dec_cmd;
  logic            dec_s, dec_b, dec_mem_r, dec_mem_w, dec_wb_en;
  logic            is_store, use_src1, use_src2, cond_ok;
  logic [XLEN-1:0] val_rn, val_rm;
  logic            sb_hazard, hazard, issue;
  sb_entry_t       sb_push;
  idex_t           ex_d, ex_q;

  assign mode    = bus.inst[27:26];
  assign imm_bit = bus.inst[25];
  assign op      = bus.inst[24:21];
  assign s_bit   = bus.inst[20];
  assign rn      = bus.inst[19:16];
  assign rd      = bus.inst[15:12];
  assign rm      = bus.inst[3:0];

  // control decode; ex_s carries the S bit of data-processing ops only
  always_comb begin
    dec_cmd   = CMD_NOP;
    dec_s     = 1'b0;
    dec_b     = 1'b0;
    dec_mem_r = 1'b0;
    dec_mem_w = 1'b0;
    dec_wb_en = 1'b0;
    case (mode)
      MODE_DP: begin
        dec_s = s_bit;
        case (op)
          OP_MOV: begin dec_cmd = CMD_MOV; dec_wb_en = 1'b1; end
          OP_MVN: begin dec_cmd = CMD_MVN; dec_wb_en = 1'b1; end
          OP_ADD: begin dec_cmd = CMD_ADD; dec_wb_en = 1'b1; end
          OP_ADC: begin dec_cmd = CMD_ADC; dec_wb_en = 1'b1; end
          OP_SUB: begin dec_cmd = CMD_SUB; dec_wb_en = 1'b1; end
          OP_SBC: begin dec_cmd = CMD_SBC; dec_wb_en = 1'b1; end
          OP_AND: begin dec_cmd = CMD_AND; dec_wb_en = 1'b1; end
          OP_ORR: begin dec_cmd = CMD_ORR; dec_wb_en = 1'b1; end
          OP_EOR: begin dec_cmd = CMD_EOR; dec_wb_en = 1'b1; end
          OP_CMP: dec_cmd = CMD_SUB;
          OP_TST: dec_cmd = CMD_AND;
          default: dec_cmd = CMD_NOP;
        endcase
      end
      MODE_MEM: begin
        dec_cmd   = CMD_ADD;
        dec_mem_r = s_bit;
        dec_mem_w = !s_bit;
        dec_wb_en = s_bit;
      end
      MODE_BR: dec_b = 1'b1;
      default: dec_cmd = CMD_NOP;
    endcase
  end

  assign is_store = (mode == MODE_MEM) && !s_bit;
  assign use_src1 = (mode != MODE_BR) &&
                    !((mode == MODE_DP) && ((op == OP_MOV) || (op == OP_MVN)));
  assign use_src2 = (!imm_bit && (mode != MODE_BR)) || is_store;
  assign src2     = is_store ? rd : rm;
  assign cond_ok  = cond_pass(bus.inst[31:28], bus.sr);

  // register read with same-cycle writeback bypass
  always_comb begin
    val_rn = (bus.wb_en && (bus.wb_dest == rn))   ? bus.wb_value : rf_q[rn];
    val_rm = (bus.wb_en && (bus.wb_dest == src2)) ? bus.wb_value : rf_q[src2];
  end

  // register file write from WB
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (bus.wb_en) begin
      rf_q[bus.wb_dest] <= bus.wb_value;
    end
  end

  assign sb_push = '{valid:   issue && cond_ok && dec_wb_en,
                     dest:    rd,
                     is_load: dec_mem_r};

  id_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .freeze_i   (bus.freeze),
    .flush_i    (bus.flush),
    .push_i     (sb_push),
    .use_src1_i (use_src1),
    .src1_i     (rn),
    .use_src2_i (use_src2),
    .src2_i     (src2),
    .hazard_o   (sb_hazard)
  );

  assign hazard         = bus.inst_valid && sb_hazard;
  assign bus.inst_ready = !hazard && !bus.freeze;
  assign issue          = bus.inst_valid && bus.inst_ready && !bus.flush;

  // ID/EX next value: flush bubbles, freeze holds, issue loads, else bubble
  always_comb begin
    ex_d = '0;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.freeze) begin
      ex_d = ex_q;
    end else if (issue) begin
      ex_d.valid         = 1'b1;
      ex_d.pc            = bus.pc;
      ex_d.imm           = imm_bit;
      ex_d.shift_operand = bus.inst[11:0];
      ex_d.simm24        = bus.inst[23:0];
      ex_d.val_rn        = val_rn;
      ex_d.val_rm        = val_rm;
      ex_d.dest          = rd;
      ex_d.src1          = rn;
      ex_d.src2          = src2;
      // a failed condition travels as a valid slot with no side effects
      if (cond_ok) begin
        ex_d.cmd   = dec_cmd;
        ex_d.s     = dec_s;
        ex_d.b     = dec_b;
        ex_d.mem_r = dec_mem_r;
        ex_d.mem_w = dec_mem_w;
        ex_d.wb_en = dec_wb_en;
      end
    end
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign bus.ex_valid         = ex_q.valid;
  assign bus.ex_pc            = ex_q.pc;
  assign bus.ex_cmd           = ex_q.cmd;
  assign bus.ex_s             = ex_q.s;
  assign bus.ex_b             = ex_q.b;
  assign bus.ex_mem_r         = ex_q.mem_r;
  assign bus.ex_mem_w         = ex_q.mem_w;
  assign bus.ex_wb_en         = ex_q.wb_en;
  assign bus.ex_imm           = ex_q.imm;
  assign bus.ex_shift_operand = ex_q.shift_operand;
  assign bus.ex_simm24        = ex_q.simm24;
  assign bus.ex_val_rn        = ex_q.val_rn;
  assign bus.ex_val_rm        = ex_q.val_rm;
  assign bus.ex_dest          = ex_q.dest;
  assign bus.ex_src1          = ex_q.src1;
  assign bus.ex_src2          = ex_q.src2;

endmodule

// File: tb/tb_id_stage_sb.sv
// Self-checking bench for id_stage_sb: directed scenarios followed by random
// traffic, all compared against an architectural model of the decode stage.
module tb_id_stage_sb;

  localparam int XLEN     = 32;
  localparam int PC_W     = 32;
  localparam int SB_DEPTH = 3;
`ifdef ID_FWD_EN
  localparam int EXP_RAW_STALLS  = 0;
  localparam int EXP_LOAD_STALLS = 1;
`else
  localparam int EXP_RAW_STALLS  = SB_DEPTH;
  localparam int EXP_LOAD_STALLS = SB_DEPTH;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_sb_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

  id_stage_sb #(.XLEN(XLEN), .PC_W(PC_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [3:0]      cmd;
    logic            s, b, mem_r, mem_w, wb_en, imm;
    logic [11:0]     shift_operand;
    logic [23:0]     simm24;
    logic [XLEN-1:0] val_rn, val_rm;
    logic [3:0]      dest, src1, src2;
  } ex_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic s, b, mr, mw, wb, use1, use2, store;
    logic [3:0] src2;
  } dec_t;

  typedef struct {
    bit       v;
    bit [3:0] d;
    bit       ld;
  } inflight_t;

  logic [XLEN-1:0] m_rf [16];
  inflight_t       m_sb [SB_DEPTH];
  ex_t             m_ex;
  logic [31:0]     pc_cnt;
  logic            last_rdy;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ARM architectural meaning of each instruction
  function automatic dec_t m_decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.use1 = 1'b1;
    case (w[27:26])
      2'b00: begin
        d.s = w[20];
        case (w[24:21])
          4'b1101: d.cmd = 4'b0001;  // MOV
          4'b1111: d.cmd = 4'b1001;  // MVN
          4'b0100: d.cmd = 4'b0010;  // ADD
          4'b0101: d.cmd = 4'b0011;  // ADC
          4'b0010: d.cmd = 4'b0100;  // SUB
          4'b0110: d.cmd = 4'b0101;  // SBC
          4'b0000: d.cmd = 4'b0110;  // AND
          4'b1100: d.cmd = 4'b0111;  // ORR
          4'b0001: d.cmd = 4'b1000;  // EOR
          4'b1010: d.cmd = 4'b0100;  // CMP
          4'b1000: d.cmd = 4'b0110;  // TST
          default: d.cmd = 4'b0000;
        endcase
        d.wb   = (d.cmd != 4'b0000) && (w[24:21] != 4'b1010) && (w[24:21] != 4'b1000);
        d.use1 = (w[24:21] != 4'b1101) && (w[24:21] != 4'b1111);
      end
      2'b01: begin
        d.cmd = 4'b0010;
        d.mr  = w[20];
        d.mw  = !w[20];
        d.wb  = w[20];
      end
      2'b10: begin
        d.b    = 1'b1;
        d.use1 = 1'b0;
      end
      default: d.cmd = 4'b0000;
    endcase
    d.store = (w[27:26] == 2'b01) && !w[20];
    d.use2  = (!w[25] && (w[27:26] != 2'b10)) || d.store;
    d.src2  = d.store ? w[15:12] : w[3:0];
    return d;
  endfunction

  // even codes test a predicate, odd codes its negation; 111x always executes
  function automatic bit m_cond(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  function automatic bit m_busy(input logic [3:0] idx);
`ifdef ID_FWD_EN
    return m_sb[0].v && m_sb[0].ld && (m_sb[0].d == idx);
`else
    foreach (m_sb[i]) if (m_sb[i].v && (m_sb[i].d == idx)) return 1'b1;
    return 1'b0;
`endif
  endfunction

  // one clock: drive at negedge, check ready, advance model, check ID/EX
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic frz, input logic fl,
                     input logic [3:0] flags, input logic we, input logic [3:0] wd,
                     input logic [31:0] wv);
    dec_t      d;
    bit        pass, hz, rdy, issue;
    ex_t       nex;
    inflight_t nsb [SB_DEPTH];
    bus.inst_valid = iv;  bus.inst = ins;   bus.pc = pc_cnt;
    bus.freeze = frz;     bus.flush = fl;   bus.sr = flags;
    bus.wb_en = we;       bus.wb_dest = wd; bus.wb_value = wv;
    d     = m_decode(ins);
    pass  = m_cond(ins[31:28], flags);
    hz    = iv && ((d.use1 && m_busy(ins[19:16])) || (d.use2 && m_busy(d.src2)));
    rdy   = !hz && !frz;
    issue = iv && rdy && !fl;
    #1;
    check("inst_ready", bus.inst_ready, rdy);
    last_rdy = rdy;
    nex = '0;
    if (fl) nex = '0;
    else if (frz) nex = m_ex;
    else if (issue) begin
      nex.valid = 1'b1;
      nex.pc = pc_cnt;
      nex.imm = ins[25];
      nex.shift_operand = ins[11:0];
      nex.simm24 = ins[23:0];
      nex.val_rn = (we && wd == ins[19:16]) ? wv : m_rf[ins[19:16]];
      nex.val_rm = (we && wd == d.src2) ? wv : m_rf[d.src2];
      nex.dest = ins[15:12];
      nex.src1 = ins[19:16];
      nex.src2 = d.src2;
      if (pass) begin
        nex.cmd = d.cmd; nex.s = d.s; nex.b = d.b;
        nex.mem_r = d.mr; nex.mem_w = d.mw; nex.wb_en = d.wb;
      end
    end
    nsb = m_sb;
    if (!frz) begin
      for (int i = SB_DEPTH - 1; i > 0; i--) nsb[i] = m_sb[i-1];
      nsb[0].v  = issue && pass && d.wb;
      nsb[0].d  = ins[15:12];
      nsb[0].ld = d.mr;
    end else if (fl) begin
      nsb[0].v = 1'b0;
    end
    @(posedge clk);
    #1;
    if (we) m_rf[wd] = wv;
    m_ex = nex;
    m_sb = nsb;
    check("ex_valid", bus.ex_valid, m_ex.valid);
    check("ex_ctrl", {bus.ex_cmd, bus.ex_s, bus.ex_b, bus.ex_mem_r, bus.ex_mem_w, bus.ex_wb_en},
          {m_ex.cmd, m_ex.s, m_ex.b, m_ex.mem_r, m_ex.mem_w, m_ex.wb_en});
    check("ex_pc", bus.ex_pc, m_ex.pc);
    check("ex_val_rn", bus.ex_val_rn, m_ex.val_rn);
    check("ex_val_rm", bus.ex_val_rm, m_ex.val_rm);
    check("ex_fields", {bus.ex_imm, bus.ex_shift_operand, bus.ex_simm24, bus.ex_dest, bus.ex_src1, bus.ex_src2},
          {m_ex.imm, m_ex.shift_operand, m_ex.simm24, m_ex.dest, m_ex.src1, m_ex.src2});
    @(negedge clk);
    pc_cnt = pc_cnt + 32'd4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic write_reg(input logic [3:0] r, input logic [31:0] v);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, r, v);
  endtask

  // present an instruction until accepted; bounded
  task automatic present(input logic [31:0] ins, input logic [3:0] flags, output int stalls);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, ins, 1'b0, 1'b0, flags, 1'b0, 4'h0, 32'h0);
      if (last_rdy) break;
      stalls++;
    end
  endtask

  function automatic logic [31:0] dp(input logic [3:0] cc, input logic [3:0] opc,
                                     input logic [3:0] rn, input logic [3:0] rd,
                                     input logic i, input logic [11:0] op2);
    return {cc, 2'b00, i, opc, 1'b0, rn, rd, op2};
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w;
    logic [3:0]  ops [11];
    int          k;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110,
            4'b1000, 4'b1010, 4'b1100, 4'b1101, 4'b1111};
    w = $urandom();
    if ($urandom_range(0, 3) != 0) w[31:28] = 4'hE;
    k = $urandom_range(0, 5);
    if (k <= 3) begin
      w[27:26] = 2'b00;
      w[24:21] = ops[$urandom_range(0, 10)];
    end else if (k == 4) begin
      w[27:26] = 2'b01;
    end else begin
      w[27:26] = 2'b10;
    end
    w[19:16] = 4'($urandom_range(0, 3));
    w[15:12] = 4'($urandom_range(0, 3));
    w[3:0]   = 4'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    pc_cnt = 32'h100;
    m_ex = '0;
    foreach (m_rf[i]) m_rf[i] = '0;
    foreach (m_sb[i]) m_sb[i] = '{v: 1'b0, d: 4'h0, ld: 1'b0};
    rst = 1'b1;
    bus.inst_valid = 1'b0; bus.inst = 32'h0; bus.pc = '0; bus.freeze = 1'b0; bus.flush = 1'b0;
    bus.sr = 4'h0; bus.wb_en = 1'b0; bus.wb_dest = 4'h0; bus.wb_value = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_ex_ctrl", {bus.ex_cmd, bus.ex_wb_en, bus.ex_mem_r, bus.ex_mem_w, bus.ex_b, bus.ex_s}, 9'h0);
    check("rst_ex_data", {bus.ex_val_rn, bus.ex_val_rm, bus.ex_dest}, 68'h0);
    @(negedge clk);
    rst = 1'b0;

    // ADD R1,R2,R3 with R2=5, R3=7
    write_reg(4'd2, 32'd5);
    write_reg(4'd3, 32'd7);
    cyc(1'b1, dp(4'hE, 4'b0100, 4'd2, 4'd1, 1'b0, 12'h003), 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0);
    check("add_valid", bus.ex_valid, 1'b1);
    check("add_cmd", bus.ex_cmd, 4'b0010);
    check("add_rn", bus.ex_val_rn, 32'd5);
    check("add_rm", bus.ex_val_rm, 32'd7);
    check("add_dest", bus.ex_dest, 4'd1);

    // SUB R4,R1,R2 right behind the producer
    present(dp(4'hE, 4'b0010, 4'd1, 4'd4, 1'b0, 12'h002), 4'h0, st);
    check("raw_stalls", st, EXP_RAW_STALLS);

    // LDR R1,[R2] then ADD R3,R1,R1
    idle(4);
    cyc(1'b1, {4'hE, 2'b01, 1'b0, 4'b1100, 1'b1, 4'd2, 4'd1, 12'h000}, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0);
    check("ldr_mem_r", bus.ex_mem_r, 1'b1);
    present(dp(4'hE, 4'b0100, 4'd1, 4'd3, 1'b0, 12'h001), 4'h0, st);
    check("load_use_stalls", st, EXP_LOAD_STALLS);

    // write-through of R2 in the reading cycle
    idle(4);
    cyc(1'b1, dp(4'hE, 4'b0100, 4'd2, 4'd5, 1'b0, 12'h000), 1'b0, 1'b0, 4'h0, 1'b1, 4'd2, 32'hAA);
    check("wt_rn", bus.ex_val_rn, 32'hAA);

    // MOVEQ R6,#1 with Z=0, then a consumer of R6
    idle(4);
    cyc(1'b1, dp(4'h0, 4'b1101, 4'd0, 4'd6, 1'b1, 12'h001), 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0);
    check("moveq_valid", bus.ex_valid, 1'b1);
    check("moveq_wb_en", bus.ex_wb_en, 1'b0);
    present(dp(4'hE, 4'b0100, 4'd6, 4'd7, 1'b0, 12'h006), 4'h0, st);
    check("moveq_dep_stalls", st, 0);

    // freeze holds ID/EX, flush bubbles and leaves no scoreboard entry
    idle(4);
    cyc(1'b1, dp(4'hE, 4'b0100, 4'd2, 4'd8, 1'b0, 12'h003), 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, dp(4'hE, 4'b0100, 4'd2, 4'd9, 1'b0, 12'h003), 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0);
      check("freeze_dest", bus.ex_dest, 4'd8);
      check("freeze_valid", bus.ex_valid, 1'b1);
    end
    cyc(1'b1, dp(4'hE, 4'b0100, 4'd2, 4'd9, 1'b0, 12'h003), 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 32'h0);
    check("flush_valid", bus.ex_valid, 1'b0);
    present(dp(4'hE, 4'b0100, 4'd9, 4'd10, 1'b0, 12'h009), 4'h0, st);
    check("flush_dep_stalls", st, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic        iv, frz, fl, we;
      logic [31:0] wv;
      iv  = ($urandom_range(0, 7) != 0);
      frz = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 1) == 1);
      wv  = $urandom();
      cyc(iv, rnd_inst(), frz, fl, 4'($urandom_range(0, 15)), we,
          4'($urandom_range(0, 4)), wv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
